// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin sharing of one pipelined cordic_fu between
// NUM_REQ requesters. A tag shift register remembers who owns each in-flight
// op, and results come back through a credit-protected FWFT response FIFO.
module cordic_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int LATENCY    = 7,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_REQ-1:0]                            req_valid,
    output logic [NUM_REQ-1:0]                            req_ready,
    input  logic [NUM_REQ*5-1:0]                          req_func,
    input  logic [NUM_REQ*18-1:0]                         req_op1,
    input  logic [NUM_REQ*18-1:0]                         req_op2,
    output logic                                          fu_valid_out,
    output logic [4:0]                                    fu_func_out,
    output logic [17:0]                                   fu_op1,
    output logic [17:0]                                   fu_op2,
    input  logic                                          fu_valid_in,
    input  logic [4:0]                                    fu_func_in,
    input  logic [25:0]                                   fu_result,
    input  logic                                          fu_override,
    input  logic [17:0]                                   fu_override_val,
    output logic                                          resp_valid,
    input  logic                                          resp_ready,
    output logic [$clog2(NUM_REQ > 1 ? NUM_REQ : 2)-1:0]  resp_id,
    output logic [4:0]                                    resp_func,
    output logic [25:0]                                   resp_result,
    output logic                                          resp_override,
    output logic [17:0]                                   resp_override_val,
    output logic                                          err
);

    localparam int ID_W = $clog2(NUM_REQ > 1 ? NUM_REQ : 2);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int UW   = $clog2(FIFO_DEPTH + LATENCY + 1);
    localparam int DW   = $clog2(LATENCY + 1);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [4:0]      func;
        logic [25:0]     result;
        logic            ovr;
        logic [17:0]     ovr_val;
    } resp_t;

    // state
    logic [DW-1:0]              drain_q;
    logic [ID_W-1:0]            rr_q, rr_d;
    logic [LATENCY-1:0]         tag_vld_q;
    logic [LATENCY-1:0][ID_W-1:0] tag_id_q;
    resp_t                      mem_q [FIFO_DEPTH];
    logic [PW-1:0]              wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       err_q, err_d;

    // combinational helpers
    logic            found, grant, issue_ok, live;
    logic [ID_W-1:0] winner;
    logic [UW-1:0]   inflight, used;
    logic            head_vld, push_req, do_push, pop, full, overflow, mismatch;
    resp_t           push_data;

    // credit accounting: FIFO occupancy plus ops still inside the FU
    always_comb begin
        inflight = '0;
        for (int k = 0; k < LATENCY; k++) begin
            inflight = inflight + UW'(tag_vld_q[k]);
        end
        used     = UW'(count_q) + inflight;
        live     = (drain_q == '0);
        issue_ok = live && (used < UW'(FIFO_DEPTH));
    end

    // round-robin search starting at the pointer, wrapping
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
                found  = 1'b1;
                winner = ID_W'((int'(rr_q) + k) % NUM_REQ);
            end
        end
        grant     = found && issue_ok;
        req_ready = '0;
        if (grant) req_ready[winner] = 1'b1;
        fu_valid_out = grant;
        fu_func_out  = req_func[5*int'(winner) +: 5];
        fu_op1       = req_op1[18*int'(winner) +: 18];
        fu_op2       = req_op2[18*int'(winner) +: 18];
        rr_d = rr_q;
        if (grant) rr_d = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
    end

    // return path: match FU output against the tag head, push, flag protocol errors
    always_comb begin
        head_vld  = tag_vld_q[LATENCY-1];
        pop       = resp_valid && resp_ready;
        full      = (count_q == CW'(FIFO_DEPTH));
        push_req  = live && fu_valid_in && head_vld;
        do_push   = push_req && (!full || pop);
        overflow  = push_req && full && !pop;
        mismatch  = live && (fu_valid_in != head_vld);
        push_data = '{id: tag_id_q[LATENCY-1], func: fu_func_in, result: fu_result,
                      ovr: fu_override, ovr_val: fu_override_val};
        wr_d      = wr_q;
        rd_d      = rd_q;
        if (do_push) wr_d = (int'(wr_q) == FIFO_DEPTH - 1) ? '0 : wr_q + 1'b1;
        if (pop)     rd_d = (int'(rd_q) == FIFO_DEPTH - 1) ? '0 : rd_q + 1'b1;
        count_d   = count_q + CW'(do_push) - CW'(pop);
        err_d     = err_q || overflow || mismatch;
    end

    // control state; the drain counter covers the unreset FU valid pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_q   <= DW'(LATENCY);
            rr_q      <= '0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (drain_q != '0) drain_q <= drain_q - 1'b1;
            rr_q        <= rr_d;
            tag_vld_q[0] <= grant;
            tag_id_q[0]  <= winner;
            for (int k = 1; k < LATENCY; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_id_q[k]  <= tag_id_q[k-1];
            end
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // FIFO payload storage; occupancy tracking makes a reset unnecessary here
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end

    assign resp_valid        = (count_q != '0);
    assign resp_id           = mem_q[rd_q].id;
    assign resp_func         = mem_q[rd_q].func;
    assign resp_result       = mem_q[rd_q].result;
    assign resp_override     = mem_q[rd_q].ovr;
    assign resp_override_val = mem_q[rd_q].ovr_val;
    assign err               = err_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: behavioural 7-stage FU with unreset valid bits,
// directed stimulus, and a scoreboard queue drained by an independent monitor.
module tb_cordic_arbiter;
    localparam int N = 4, LAT = 7, DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0, req_ready;
    logic [N*5-1:0]  req_func = '0;
    logic [N*18-1:0] req_op1 = '0, req_op2 = '0;
    logic            fu_valid_out, fu_valid_in, fu_override, resp_valid, resp_override, err;
    logic [4:0]      fu_func_out, fu_func_in, resp_func;
    logic [17:0]     fu_op1, fu_op2, fu_override_val, resp_override_val;
    logic [25:0]     fu_result, resp_result;
    logic [1:0]      resp_id;
    logic            resp_ready = 1'b1;
    logic            force_vin = 1'b0;

    cordic_arbiter #(.NUM_REQ(N), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
        .req_op1(req_op1), .req_op2(req_op2),
        .fu_valid_out(fu_valid_out), .fu_func_out(fu_func_out), .fu_op1(fu_op1), .fu_op2(fu_op2),
        .fu_valid_in(fu_valid_in), .fu_func_in(fu_func_in), .fu_result(fu_result),
        .fu_override(fu_override), .fu_override_val(fu_override_val),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_func(resp_func), .resp_result(resp_result), .resp_override(resp_override),
        .resp_override_val(resp_override_val), .err(err)
    );

    // FU stand-in: result and override are simple functions of the operands
    function automatic logic [25:0] m_res(input logic [4:0] f, input logic [17:0] a, input logic [17:0] b);
        return {f, a ^ b, 3'b101};
    endfunction

    logic [LAT-1:0] fv;
    logic [4:0]     ff [LAT];
    logic [17:0]    fa [LAT], fb [LAT];
    initial fv = 7'b1011011;   // garbage valid bits, as after power-up

    always @(posedge clk) begin
        fv    <= {fv[LAT-2:0], fu_valid_out};
        ff[0] <= fu_func_out;
        fa[0] <= fu_op1;
        fb[0] <= fu_op2;
        for (int k = 1; k < LAT; k++) begin
            ff[k] <= ff[k-1];
            fa[k] <= fa[k-1];
            fb[k] <= fb[k-1];
        end
    end

    assign fu_valid_in     = fv[LAT-1] | force_vin;
    assign fu_func_in      = ff[LAT-1];
    assign fu_result       = m_res(ff[LAT-1], fa[LAT-1], fb[LAT-1]);
    assign fu_override     = (fa[LAT-1] == 18'h3FFFF);
    assign fu_override_val = (fa[LAT-1] == 18'h3FFFF) ? fa[LAT-1] : 18'h0;

    typedef struct packed {
        logic [1:0]  id;
        logic [4:0]  f;
        logic [25:0] r;
        logic        o;
        logic [17:0] ov;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    logic [4:0]  rf [N];
    logic [17:0] ra [N], rb [N];
    logic        rdy_cfg = 1'b1;
    logic        frc_cfg = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] f, input logic [17:0] a, input logic [17:0] b);
        rf[i] = f;
        ra[i] = a;
        rb[i] = b;
    endtask

    // one cycle: apply inputs after the edge, check grant mid-cycle, log the expected response
    task automatic tick(input logic [N-1:0] rv, input logic [N-1:0] er, input string nm);
        int   id;
        exp_t e;
        @(posedge clk); #1;
        req_valid  = rv;
        resp_ready = rdy_cfg;
        force_vin  = frc_cfg;
        for (int i = 0; i < N; i++) begin
            req_func[5*i +: 5]  = rf[i];
            req_op1[18*i +: 18] = ra[i];
            req_op2[18*i +: 18] = rb[i];
        end
        @(negedge clk);
        chk(nm, 64'(req_ready), 64'(er));
        if (er != '0) begin
            id = 0;
            for (int i = 0; i < N; i++) if (er[i]) id = i;
            chk({nm, "_fu_valid"}, 64'(fu_valid_out), 64'd1);
            chk({nm, "_fu_op"}, 64'({fu_func_out, fu_op1, fu_op2}), 64'({rf[id], ra[id], rb[id]}));
            e.id = 2'(id);
            e.f  = rf[id];
            e.r  = m_res(rf[id], ra[id], rb[id]);
            e.o  = (ra[id] == 18'h3FFFF);
            e.ov = e.o ? ra[id] : 18'h0;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick('0, '0, "idle_grant");
    endtask

    // reset for one cycle; in-flight and queued responses are forgotten
    task automatic do_reset(input logic [N-1:0] rv);
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_fu_valid", 64'(fu_valid_out), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = rv;
        @(negedge clk);
        chk("drain_c0_grant", 64'(req_ready), 64'd0);
    endtask

    // monitor: every accepted response must match the scoreboard head
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual id=%0d func=%0h required none", resp_id, resp_func);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp", 64'({resp_id, resp_func, resp_result, resp_override, resp_override_val}), 64'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), 18'(16 * (i + 1)), 18'(i + 3));

        // T1: single request after drain
        do_reset('0);
        idle(6);
        set_req(2, 5'h0B, 18'h00100, 18'h00023);
        tick(4'b0100, 4'b0100, "t1_grant");
        idle(6);
        tick('0, '0, "t1_idle");
        chk("t1_resp_valid_t7", 64'(resp_valid), 64'd0);
        tick('0, '0, "t1_idle");
        chk("t1_resp_valid_t8", 64'(resp_valid), 64'd1);
        idle(2);

        // T2: fairness from rr=0, responses back-to-back
        do_reset('0);
        idle(6);
        for (int i = 0; i < N; i++) set_req(i, 5'(i + 8), 18'(18'h01000 + i), 18'(18'h00500 * (i + 1)));
        for (int k = 0; k < 8; k++) tick(4'hF, 4'(1 << (k % 4)), "t2_grant");
        for (int k = 0; k < 8; k++) begin
            tick('0, '0, "t2_idle");
            chk("t2_resp_streak", 64'(resp_valid), 64'd1);
        end
        idle(3);

        // T3: backpressure limits issue to FIFO_DEPTH credits
        rdy_cfg = 1'b0;
        for (int k = 0; k < 8; k++) tick(4'hF, 4'(1 << (k % 4)), "t3_grant");
        repeat (12) tick(4'hF, '0, "t3_stall");
        chk("t3_full_valid", 64'(resp_valid), 64'd1);
        chk("t3_err", 64'(err), 64'd0);
        rdy_cfg = 1'b1;
        tick(4'hF, '0, "t3_first_pop");
        for (int k = 0; k < 4; k++) tick(4'hF, 4'(1 << k), "t3_resume");
        tick('0, '0, "t3_idle");
        idle(20);
        chk("t3_all_returned", 64'(exp_q.size()), 64'd0);
        chk("t3_err_end", 64'(err), 64'd0);

        // T4: reset with three ops in flight
        tick(4'hF, 4'b0001, "t4_pre");
        tick(4'hF, 4'b0010, "t4_pre");
        tick(4'hF, 4'b0100, "t4_pre");
        do_reset(4'hF);
        for (int k = 0; k < 6; k++) begin
            tick(4'hF, '0, "t4_drain");
            chk("t4_no_resp", 64'(resp_valid), 64'd0);
        end
        tick(4'hF, 4'b0001, "t4_after");
        tick('0, '0, "t4_idle");
        idle(10);
        chk("t4_err", 64'(err), 64'd0);

        // T5: override passthrough
        set_req(1, 5'h1F, 18'h3FFFF, 18'h00001);
        tick(4'b0010, 4'b0010, "t5_grant");
        idle(10);
        chk("t5_drained", 64'(exp_q.size()), 64'd0);

        // T6: FU valid with no matching tag
        chk("t6_err_before", 64'(err), 64'd0);
        frc_cfg = 1'b1;
        tick('0, '0, "t6_force");
        chk("t6_err_same_cycle", 64'(err), 64'd0);
        frc_cfg = 1'b0;
        tick('0, '0, "t6_after");
        chk("t6_err_set", 64'(err), 64'd1);
        chk("t6_no_push", 64'(resp_valid), 64'd0);
        idle(3);
        chk("t6_err_sticky", 64'(err), 64'd1);

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
